tensor_writeback_queue: RTL and testbench

TENSOR_WRITEBACK_QUEUE -- requirements
Module: tensor_writeback_queue

---
 rtl/tensor_writeback_queue.sv | 154 +++++++++++++++
 tb/tb_tensor_writeback_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tensor_writeback_queue.sv
// Tensor result writeback queue.
// Buffers DEPTH complete 4x4 tensor results and drains each one to the
// register file as four 128-bit row writes under a valid/ready handshake.
// A one-cycle warp_wb_done pulse follows acceptance of the last row.
// Optional feature macro: TWB_DROP_CNT_EN adds an 8-bit saturating
// drop_count output next to the sticky overflow flag.
module tensor_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [1:0]                    in_warp_id,
  input  logic [3:0]                    in_reg_idx,
  input  logic signed [16*DATA_W-1:0]   in_data,
  output logic                          rf_wr_valid,
  input  logic                          rf_wr_ready,
  output logic [1:0]                    rf_wr_warp_id,
  output logic [3:0]                    rf_wr_reg_idx,
  output logic [1:0]                    rf_wr_row,
  output logic signed [4*DATA_W-1:0]    rf_wr_data,
  output logic [3:0]                    warp_wb_done,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_count,
  output logic                          full,
  output logic                          overflow
`ifdef TWB_DROP_CNT_EN
  ,
  output logic [7:0]                    drop_count
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int ROW_W = 4*DATA_W;
  localparam int ENT_W = 16*DATA_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count, count_nxt;
  logic [1:0]               row;
  logic [3:0]               done_p1;

  logic [1:0]               mem_warp [DEPTH];
  logic [3:0]               mem_reg  [DEPTH];
  logic signed [ENT_W-1:0]  mem_data [DEPTH];
  logic signed [ENT_W-1:0]  head_data;

  logic hs, pop, push, drop;

  // Handshake, pop and push/drop qualification; a pop frees a slot for a
  // push arriving in the same cycle even when the queue is full.
  assign full = (count == DEPTH_C);
  assign hs   = rf_wr_valid & rf_wr_ready;
  assign pop  = hs & (row == 2'd3);
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  // Occupancy after this cycle's push/pop; also steers the FSM so a push
  // into an empty queue is presented on the very next cycle.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + ONE_C;
      2'b01:   count_nxt = count - ONE_C;
      default: count_nxt = count;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: drain while anything is held after this cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count_nxt != '0)        state_nxt = DRAIN;
      DRAIN:   if (pop && count_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    rf_wr_valid = (state == DRAIN);
  end

  // Control state: pointers, occupancy, row counter, done pulse, sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      row      <= 2'd0;
      done_p1  <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      // Row 3 + 1 wraps to 0, which is exactly the post-pop row.
      if (hs)   row <= row + 2'd1;
      done_p1 <= pop ? (4'b0001 << mem_warp[rd_ptr]) : 4'd0;
      if (drop) overflow <= 1'b1;
    end
  end

  // Payload storage; not reset, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_warp[wr_ptr] <= in_warp_id;
      mem_reg[wr_ptr]  <= in_reg_idx;
      mem_data[wr_ptr] <= in_data;
    end
  end

  assign head_data     = mem_data[rd_ptr];
  assign rf_wr_warp_id = mem_warp[rd_ptr];
  assign rf_wr_reg_idx = mem_reg[rd_ptr];
  assign rf_wr_row     = row;
  assign warp_wb_done  = done_p1;
  assign fifo_count    = count;

  // Row select from the head entry; stable while head and row are held.
  always_comb begin
    rf_wr_data = head_data[ROW_W-1:0];
    case (row)
      2'd1:    rf_wr_data = head_data[2*ROW_W-1:ROW_W];
      2'd2:    rf_wr_data = head_data[3*ROW_W-1:2*ROW_W];
      2'd3:    rf_wr_data = head_data[4*ROW_W-1:3*ROW_W];
      default: rf_wr_data = head_data[ROW_W-1:0];
    endcase
  end

`ifdef TWB_DROP_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Saturating count of dropped results.
  always_ff @(posedge clk) begin
    if (reset)     drop_count <= 8'd0;
    else if (drop) drop_count <= sat_inc8(drop_count);
  end
`endif

endmodule

// File: tb/tb_tensor_writeback_queue.sv
// Self-checking bench for tensor_writeback_queue: directed scenarios then a
// random phase, all compared each cycle against a queue-based reference.
module tb_tensor_writeback_queue;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [1:0]   in_warp_id;
  logic [3:0]   in_reg_idx;
  logic [511:0] in_data;
  logic         rf_wr_valid;
  logic         rf_wr_ready;
  logic [1:0]   rf_wr_warp_id;
  logic [3:0]   rf_wr_reg_idx;
  logic [1:0]   rf_wr_row;
  logic [127:0] rf_wr_data;
  logic [3:0]   warp_wb_done;
  logic [2:0]   fifo_count;
  logic         full;
  logic         overflow;
`ifdef TWB_DROP_CNT_EN
  logic [7:0]   drop_count;
`endif

  tensor_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_warp_id(in_warp_id),
    .in_reg_idx(in_reg_idx), .in_data(in_data), .rf_wr_valid(rf_wr_valid),
    .rf_wr_ready(rf_wr_ready), .rf_wr_warp_id(rf_wr_warp_id),
    .rf_wr_reg_idx(rf_wr_reg_idx), .rf_wr_row(rf_wr_row),
    .rf_wr_data(rf_wr_data), .warp_wb_done(warp_wb_done),
    .fifo_count(fifo_count), .full(full), .overflow(overflow)
`ifdef TWB_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   w;
    logic [3:0]   r;
    logic [511:0] d;
  } ent_t;

  ent_t       q[$];
  int         mrow;
  logic [3:0] mdone;
  bit         movf;
  int         mdrops;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] x;
    for (int i = 0; i < 16; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  // Valid whenever the model holds an entry; write target is head/row.
  task automatic check_outputs();
    ent_t h;
    chk("rf_wr_valid", rf_wr_valid, q.size() > 0);
    if (q.size() > 0) begin
      h = q[0];
      chk("rf_wr_warp_id", rf_wr_warp_id, h.w);
      chk("rf_wr_reg_idx", rf_wr_reg_idx, h.r);
      chk("rf_wr_row", rf_wr_row, mrow);
      chk("rf_wr_data", rf_wr_data, h.d[mrow*128 +: 128]);
    end
    chk("fifo_count", fifo_count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("overflow", overflow, movf);
    chk("warp_wb_done", warp_wb_done, mdone);
`ifdef TWB_DROP_CNT_EN
    chk("drop_count", drop_count, mdrops);
`endif
  endtask

  // Reference behaviour for one clock edge with the given inputs.
  task automatic model_step(input bit v, input bit rdy, input bit rst,
                            input logic [1:0] w, input logic [3:0] r, input logic [511:0] d);
    bit   pop, push;
    ent_t e;
    if (rst) begin
      q.delete();
      mrow = 0; mdone = 4'd0; movf = 0; mdrops = 0;
      return;
    end
    pop  = (q.size() > 0) && rdy && (mrow == 3);
    push = v && ((q.size() < DEPTH) || pop);
    mdone = 4'd0;
    if ((q.size() > 0) && rdy) begin
      if (mrow == 3) begin
        mdone = 4'd1 << q[0].w;
        void'(q.pop_front());
        mrow = 0;
      end else begin
        mrow++;
      end
    end
    if (v && !push) begin
      movf = 1;
      if (mdrops < 255) mdrops++;
    end
    if (push) begin
      e.w = w; e.r = r; e.d = d;
      q.push_back(e);
    end
  endtask

  task automatic cycle(input bit v, input bit rdy, input bit rst,
                       input logic [1:0] w, input logic [3:0] r, input logic [511:0] d);
    check_outputs();
    reset = rst; in_valid = v; in_warp_id = w; in_reg_idx = r; in_data = d;
    rf_wr_ready = rdy;
    model_step(v, rdy, rst, w, r, d);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, rdy, 1'b0, 2'd0, 4'd0, '0);
  endtask

  task automatic push_rnd(input bit rdy, input logic [1:0] w);
    cycle(1'b1, rdy, 1'b0, w, 4'($urandom_range(0, 15)), rnd512());
  endtask

  initial begin
    logic [511:0] pat;
    pat = {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}};
    reset = 1'b1; in_valid = 1'b0; in_warp_id = '0; in_reg_idx = '0;
    in_data = '0; rf_wr_ready = 1'b0;
    @(posedge clk); #1;
    model_step(1'b0, 1'b0, 1'b1, 2'd0, 4'd0, '0);

    // Reset holds, with in_valid ignored during reset.
    cycle(1'b1, 1'b1, 1'b1, 2'd1, 4'd3, rnd512());
    idle(2, 1'b1);

    // Single push, warp 2 reg 5, ready high.
    cycle(1'b1, 1'b1, 1'b0, 2'd2, 4'd5, pat);
    idle(7, 1'b1);

    // Backpressure pattern during drain.
    push_rnd(1'b1, 2'd1);
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, '0);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, '0);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, '0);
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, '0);
    idle(6, 1'b1);

    // Overflow: five pushes with ready low, then drain.
    for (int i = 0; i < 5; i++) push_rnd(1'b0, 2'(i));
    idle(3, 1'b0);
    idle(20, 1'b1);

    // Full queue with a push coinciding with the row-3 handshake.
    cycle(1'b0, 1'b0, 1'b1, 2'd0, 4'd0, '0);
    for (int i = 0; i < 4; i++) push_rnd(1'b0, 2'(3 - i));
    idle(3, 1'b1);
    push_rnd(1'b1, 2'd2);
    idle(22, 1'b1);

    // Reset after row 1 accepted, then a fresh drain from row 0.
    push_rnd(1'b1, 2'd3);
    idle(2, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 2'd0, 4'd0, '0);
    idle(1, 1'b1);
    push_rnd(1'b1, 2'd0);
    idle(6, 1'b1);

    // Back-to-back results from warps 0, 1, 3.
    push_rnd(1'b1, 2'd0);
    push_rnd(1'b1, 2'd1);
    push_rnd(1'b1, 2'd3);
    idle(15, 1'b1);

    // Random traffic with random backpressure and occasional reset.
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom % 3) == 0, ($urandom % 4) != 0, ($urandom % 200) == 0,
            2'($urandom), 4'($urandom), rnd512());
    end
    idle(30, 1'b1);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
